// File: rtl/bitserial_plane_seq_pkg.sv
// Shared types and default sizes for the bit-serial vector datapath.
package bitserial_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_VEC_LENGTH = 8;
  localparam int IDX_W          = $clog2(DEF_DATA_WIDTH);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/bitserial_plane_seq_if.sv
// Vector-in / bit-plane-out handshake bundle for bitserial_plane_seq.
interface bitserial_plane_seq_if
  import bitserial_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int VEC_LENGTH = DEF_VEC_LENGTH
);
  logic                                 in_valid;
  logic                                 in_ready;
  logic [VEC_LENGTH-1:0][DATA_WIDTH-1:0] in_vec;
  logic                                 out_valid;
  logic                                 out_ready;
  logic [VEC_LENGTH-1:0]                out_bits;
  logic [$clog2(DATA_WIDTH)-1:0]        out_idx;
  logic                                 out_neg;
  logic                                 out_last;
  logic                                 busy;

  modport master (
    output in_valid, in_vec, out_ready,
    input  in_ready, out_valid, out_bits, out_idx, out_neg, out_last, busy
  );

  modport slave (
    input  in_valid, in_vec, out_ready,
    output in_ready, out_valid, out_bits, out_idx, out_neg, out_last, busy
  );
endinterface

// File: rtl/bitserial_plane_seq_finder.sv
// Priority finder: highest set bit of mask strictly below cur.
// Only compiled when ZERO_PLANE_SKIP_EN is defined.
`ifdef ZERO_PLANE_SKIP_EN
module bs_plane_finder #(
  parameter int W  = 8,
  parameter int IW = $clog2(W)
) (
  input  logic [W-1:0]  mask,
  input  logic [IW-1:0] cur,
  output logic [IW-1:0] next_idx,
  output logic          none_left
);

  always_comb begin
    next_idx  = '0;
    none_left = 1'b1;
    for (int i = 0; i < W; i++) begin
      if (i < int'(cur) && mask[i]) begin
        next_idx  = IW'(i);
        none_left = 1'b0;
      end
    end
  end

endmodule
`endif

// File: rtl/bitserial_plane_seq.sv
// Captures a signed lane vector and replays it as MSB-first bit-planes.
// ZERO_PLANE_SKIP_EN: emit only planes with at least one bit set.
//
//   state | meaning
//   IDLE  | no vector held, ready for input
//   SHIFT | vector held, presenting plane out_idx
module bitserial_plane_seq
  import bitserial_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int VEC_LENGTH = DEF_VEC_LENGTH
) (
  input logic clk,
  input logic reset,
  bitserial_plane_seq_if.slave bus
);

  localparam int IW = $clog2(DATA_WIDTH);
  localparam logic [IW-1:0] TOP = IW'(DATA_WIDTH - 1);

  typedef logic [VEC_LENGTH-1:0][DATA_WIDTH-1:0] vec_t;

  state_t                state;
  vec_t                  vec_q;
  logic [IW-1:0]         idx_q;
  logic [VEC_LENGTH-1:0] bits_q;
  logic                  neg_q;
  logic                  last_q;

  logic                  take_in;
  logic                  take_out;
  logic [IW-1:0]         first_idx;
  logic                  first_last;
  logic [IW-1:0]         next_idx;
  logic                  next_last;

  function automatic logic [VEC_LENGTH-1:0] plane(input vec_t v, input logic [IW-1:0] b);
    logic [VEC_LENGTH-1:0] p;
    p = '0;
    for (int j = 0; j < VEC_LENGTH; j++) p[j] = v[j][b];
    return p;
  endfunction

  assign take_out     = (state == SHIFT) && bus.out_ready;
  assign bus.in_ready = (state == IDLE) || (take_out && last_q);
  assign take_in      = bus.in_valid && bus.in_ready;

`ifdef ZERO_PLANE_SKIP_EN
  logic [DATA_WIDTH-1:0] mask_in;
  logic [DATA_WIDTH-1:0] mask_q;
  logic [IW-1:0]         top_below;
  logic                  top_none;
  logic                  cap_none;
  logic [IW-1:0]         unused_cap_idx;
  logic                  unused_step_none;

  always_comb begin
    mask_in = '0;
    mask_q  = '0;
    for (int b = 0; b < DATA_WIDTH; b++) begin
      for (int j = 0; j < VEC_LENGTH; j++) begin
        mask_in[b] = mask_in[b] | bus.in_vec[j][b];
        mask_q[b]  = mask_q[b]  | vec_q[j][b];
      end
    end
  end

  // The finder only looks strictly below its index, so the top plane is tested directly.
  bs_plane_finder #(.W(DATA_WIDTH), .IW(IW)) u_find_top (
    .mask(mask_in), .cur(TOP), .next_idx(top_below), .none_left(top_none)
  );
  bs_plane_finder #(.W(DATA_WIDTH), .IW(IW)) u_find_cap (
    .mask(mask_in), .cur(top_below), .next_idx(unused_cap_idx), .none_left(cap_none)
  );
  bs_plane_finder #(.W(DATA_WIDTH), .IW(IW)) u_find_step (
    .mask(mask_q), .cur(idx_q), .next_idx(next_idx), .none_left(unused_step_none)
  );
  bs_plane_finder #(.W(DATA_WIDTH), .IW(IW)) u_find_last (
    .mask(mask_q), .cur(next_idx), .next_idx(), .none_left(next_last)
  );

  assign first_idx  = mask_in[DATA_WIDTH-1] ? TOP : top_below;
  assign first_last = mask_in[DATA_WIDTH-1] ? top_none : cap_none;
`else
  assign first_idx  = TOP;
  assign first_last = (DATA_WIDTH == 1);
  assign next_idx   = idx_q - IW'(1);
  assign next_last  = (idx_q == IW'(1));
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      vec_q  <= '0;
      idx_q  <= '0;
      bits_q <= '0;
      neg_q  <= 1'b0;
      last_q <= 1'b0;
    end else if (take_in) begin
      state  <= SHIFT;
      vec_q  <= bus.in_vec;
      idx_q  <= first_idx;
      bits_q <= plane(bus.in_vec, first_idx);
      neg_q  <= (first_idx == TOP);
      last_q <= first_last;
    end else if (take_out) begin
      if (last_q) begin
        state  <= IDLE;
        idx_q  <= '0;
        bits_q <= '0;
        neg_q  <= 1'b0;
        last_q <= 1'b0;
      end else begin
        idx_q  <= next_idx;
        bits_q <= plane(vec_q, next_idx);
        neg_q  <= (next_idx == TOP);
        last_q <= next_last;
      end
    end
  end

  assign bus.out_valid = (state == SHIFT);
  assign bus.busy      = (state == SHIFT);
  assign bus.out_bits  = bits_q;
  assign bus.out_idx   = idx_q;
  assign bus.out_neg   = neg_q;
  assign bus.out_last  = last_q;

endmodule

// File: tb/tb_bitserial_plane_seq.sv
// Randomized bench for bitserial_plane_seq against a plane-list reference model.
module tb_bitserial_plane_seq;

  localparam int DW = 8;
  localparam int VL = 8;

  typedef struct packed {
    logic [2:0]    idx;
    logic [VL-1:0] bits;
    logic          neg;
    logic          last;
  } plane_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  bitserial_plane_seq_if #(.DATA_WIDTH(DW), .VEC_LENGTH(VL)) bus ();

  bitserial_plane_seq #(.DATA_WIDTH(DW), .VEC_LENGTH(VL)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int     n_cmp = 0;
  int     n_err = 0;
  plane_t q[$];
  bit     after_reset = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected plane list for one vector, straight from the emission rules.
  function automatic void gen_planes(input logic [VL-1:0][DW-1:0] v);
    plane_t p;
    bit any = 1'b0;
    for (int b = DW - 1; b >= 0; b--) begin
      p.bits = '0;
      for (int j = 0; j < VL; j++) p.bits[j] = v[j][b];
      p.idx  = 3'(b);
      p.neg  = (b == DW - 1);
      p.last = 1'b0;
`ifdef ZERO_PLANE_SKIP_EN
      if (p.bits == '0) continue;
`endif
      q.push_back(p);
      any = 1'b1;
    end
    if (!any) begin
      p = '0;
      q.push_back(p);
    end
    q[q.size()-1].last = 1'b1;
  endfunction

  task automatic monitor();
    bit exp_rdy;
    if (reset) begin
      q.delete();
      after_reset = 1'b1;
      return;
    end
    if (after_reset) begin
      chk("rst_bits", 32'(bus.out_bits), 0);
      chk("rst_idx",  32'(bus.out_idx), 0);
      chk("rst_neg",  32'(bus.out_neg), 0);
      chk("rst_last", 32'(bus.out_last), 0);
      after_reset = 1'b0;
    end
    exp_rdy = (q.size() == 0) || (q.size() == 1 && bus.out_ready);
    chk("out_valid", 32'(bus.out_valid), 32'(q.size() != 0));
    chk("busy",      32'(bus.busy), 32'(q.size() != 0));
    chk("in_ready",  32'(bus.in_ready), 32'(exp_rdy));
    if (q.size() != 0) begin
      chk("out_idx",  32'(bus.out_idx),  32'(q[0].idx));
      chk("out_bits", 32'(bus.out_bits), 32'(q[0].bits));
      chk("out_neg",  32'(bus.out_neg),  32'(q[0].neg));
      chk("out_last", 32'(bus.out_last), 32'(q[0].last));
      if (bus.out_ready) void'(q.pop_front());
    end
    if (bus.in_valid && exp_rdy) gen_planes(bus.in_vec);
  endtask

  task automatic step();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_vec();
    logic [DW-1:0] sm;
    sm = DW'($urandom & $urandom);
    if ($urandom_range(0, 7) == 0) sm = '0;
    for (int j = 0; j < VL; j++) bus.in_vec[j] = DW'($urandom) & sm;
  endtask

  task automatic send_one();
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_vec    = '0;
    bus.out_ready = 1'b1;
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    step();

    // all lanes 0x81: sign plane and LSB plane full, middle planes empty
    for (int j = 0; j < VL; j++) bus.in_vec[j] = 8'h81;
    send_one();
    repeat (9) step();

    // back-pressure while plane 5 is presented
    rand_vec();
    for (int j = 0; j < VL; j++) bus.in_vec[j][5] = 1'b1;
    send_one();
    repeat (2) step();
    bus.out_ready = 1'b0;
    repeat (3) step();
    bus.out_ready = 1'b1;
    repeat (7) step();

    // in_valid held high: back-to-back vectors, lanes change every cycle
    bus.in_valid = 1'b1;
    for (int k = 0; k < 20; k++) begin
      rand_vec();
      step();
    end
    bus.in_valid = 1'b0;
    repeat (9) step();

    // sparse vector then all-zero vector
    bus.in_vec = '0;
    bus.in_vec[0] = 8'h05;
    send_one();
    repeat (9) step();
    bus.in_vec = '0;
    send_one();
    repeat (9) step();

    // reset while plane 4 is presented, then a fresh vector
    for (int j = 0; j < VL; j++) bus.in_vec[j] = 8'($urandom);
    send_one();
    repeat (3) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int j = 0; j < VL; j++) bus.in_vec[j] = 8'($urandom);
    send_one();
    repeat (9) step();

    for (int k = 0; k < 1500; k++) begin
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      reset         = ($urandom_range(0, 149) == 0);
      rand_vec();
      step();
    end
    reset         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    repeat (10) step();
    chk("drained", 32'(q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
